// File: rtl/axis_dnsz_pkg.sv
// Shared types and helpers for the AXI4-Stream N:1 width down-converter.
package axis_dnsz_pkg;

   localparam int unsigned MaxRatio = 64;
   localparam int unsigned MaxIdxW  = 6;

   typedef logic [MaxIdxW-1:0] sub_idx_t;

   function automatic int unsigned idx_width(input int unsigned ratio);
      return (ratio <= 2) ? 1 : $clog2(ratio);
   endfunction

   function automatic logic is_single_bit(input logic [MaxRatio-1:0] v);
      return (v != '0) && ((v & (v - {{(MaxRatio-1){1'b0}}, 1'b1})) == '0);
   endfunction

endpackage

// File: rtl/dnsz_first_set.sv
// Priority encoder: index of the first set bit, scanning from the top (DIR=1) or bottom (DIR=0).
module dnsz_first_set
   import axis_dnsz_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter bit          DIR   = 1'b1,
   localparam int unsigned IdxW = idx_width(WIDTH)
) (
   input  logic [WIDTH-1:0] vec_i,
   output logic [IdxW-1:0]  idx_o,
   output logic             valid_o
);

   // Later loop iterations overwrite earlier ones, so the last match scanned wins.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (DIR) begin
            if (vec_i[i]) begin
               idx_o   = IdxW'(i);
               valid_o = 1'b1;
            end
         end else begin
            if (vec_i[WIDTH-1-i]) begin
               idx_o   = IdxW'(WIDTH - 1 - i);
               valid_o = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/axis_downsizer_n.sv
// AXI4-Stream width down-converter: splits each W*RATIO-bit beat into up to RATIO W-bit beats,
// skipping sub-words whose keep bit is clear.
module axis_downsizer_n
   import axis_dnsz_pkg::*;
#(
   parameter int unsigned W         = 32,
   parameter int unsigned RATIO     = 4,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic [W*RATIO-1:0] in_tdata,
   input  logic [RATIO-1:0]   in_tkeep,
   input  logic               in_tlast,
   input  logic               in_tvalid,
   output logic               in_tready,
   output logic [W-1:0]       out_tdata,
   output logic               out_tlast,
   output logic               out_tvalid,
   input  logic               out_tready,
   output logic               null_last
);

   localparam int unsigned IdxW = idx_width(RATIO);

   logic [W*RATIO-1:0] data_q, data_d;
   logic               last_q, last_d;
   logic [RATIO-1:0]   pend_q, pend_d;
   logic               null_q, null_d;

   logic [IdxW-1:0]    sel_idx;
   logic               sel_valid;
   logic [RATIO-1:0]   sel_oh;
   logic               single;
   logic               in_hs;
   logic               out_hs;

   dnsz_first_set #(
      .WIDTH (RATIO),
      .DIR   (MSB_FIRST)
   ) u_sel (
      .vec_i   (pend_q),
      .idx_o   (sel_idx),
      .valid_o (sel_valid)
   );

   assign single     = is_single_bit(MaxRatio'(pend_q));
   assign out_tvalid = sel_valid;
   assign out_tlast  = last_q & single;
   // Accept while the final pending sub-word leaves, so back-to-back beats have no bubble.
   assign in_tready  = ~sel_valid | (out_tready & single);
   assign in_hs      = in_tvalid & in_tready;
   assign out_hs     = sel_valid & out_tready;
   assign null_last  = null_q;

   always_comb begin
      out_tdata = '0;
      sel_oh    = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (sub_idx_t'(sel_idx) == sub_idx_t'(k)) begin
            out_tdata = data_q[k*W +: W];
            sel_oh[k] = 1'b1;
         end
      end
   end

   always_comb begin
      data_d = data_q;
      last_d = last_q;
      pend_d = pend_q;
      null_d = 1'b0;
      if (out_hs) begin
         pend_d = pend_q & ~sel_oh;
      end
      if (in_hs) begin
         data_d = in_tdata;
         last_d = in_tlast;
         pend_d = in_tkeep;
         null_d = in_tlast & (in_tkeep == '0);
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         data_q <= '0;
         last_q <= 1'b0;
         pend_q <= '0;
         null_q <= 1'b0;
      end else begin
         data_q <= data_d;
         last_q <= last_d;
         pend_q <= pend_d;
         null_q <= null_d;
      end
   end

endmodule

// File: tb/tb_axis_downsizer_n.sv
// Bench for axis_downsizer_n: MSB-first and LSB-first instances driven by the same stimulus.
module tb_axis_downsizer_n;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } sb_t;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      int          n_out;
      logic [7:0]  last_m;
      logic [7:0]  last_l;
   } vec_t;

   logic        aclk       = 1'b0;
   logic        aresetn    = 1'b0;
   logic [31:0] in_tdata   = '0;
   logic [3:0]  in_tkeep   = '0;
   logic        in_tlast   = 1'b0;
   logic        in_tvalid  = 1'b0;
   logic        out_tready = 1'b1;

   logic [7:0] o_data  [2];
   logic       o_last  [2];
   logic       o_valid [2];
   logic       i_ready [2];
   logic       n_last  [2];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 aclk = ~aclk;

   initial forever begin
      @(posedge aclk);
      cyc++;
   end

   axis_downsizer_n #(.W(8), .RATIO(4), .MSB_FIRST(1'b1)) u_msb (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .in_tdata   (in_tdata),
      .in_tkeep   (in_tkeep),
      .in_tlast   (in_tlast),
      .in_tvalid  (in_tvalid),
      .in_tready  (i_ready[0]),
      .out_tdata  (o_data[0]),
      .out_tlast  (o_last[0]),
      .out_tvalid (o_valid[0]),
      .out_tready (out_tready),
      .null_last  (n_last[0])
   );

   axis_downsizer_n #(.W(8), .RATIO(4), .MSB_FIRST(1'b0)) u_lsb (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .in_tdata   (in_tdata),
      .in_tkeep   (in_tkeep),
      .in_tlast   (in_tlast),
      .in_tvalid  (in_tvalid),
      .in_tready  (i_ready[1]),
      .out_tdata  (o_data[1]),
      .out_tlast  (o_last[1]),
      .out_tvalid (o_valid[1]),
      .out_tready (out_tready),
      .null_last  (n_last[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-instance scoreboard: expected sub-words queued on input handshake, popped on output.
   for (genvar g = 0; g < 2; g++) begin : g_mon
      sb_t        q[$];
      int         out_cnt   = 0;
      int         last_cyc  = 0;
      logic [7:0] last_data = '0;
      bit         null_exp  = 1'b0;
      bit         prev_stall = 1'b0;
      logic [7:0] prev_data = '0;
      logic       prev_last = 1'b0;

      initial forever begin
         int  k;
         int  total;
         int  pushed;
         sb_t e;
         @(negedge aclk);
         if (!aresetn) begin
            q.delete();
            null_exp   = 1'b0;
            prev_stall = 1'b0;
         end else begin
            chk($sformatf("out_tvalid[%0d]", g), 32'(o_valid[g]), 32'(q.size() != 0));
            chk($sformatf("in_tready[%0d]", g), 32'(i_ready[g]),
                32'((q.size() == 0) || (out_tready && q.size() == 1)));
            chk($sformatf("null_last[%0d]", g), 32'(n_last[g]), 32'(null_exp));
            if (prev_stall) begin
               chk($sformatf("stall_data[%0d]", g), 32'(o_data[g]), 32'(prev_data));
               chk($sformatf("stall_last[%0d]", g), 32'(o_last[g]), 32'(prev_last));
            end
            if (o_valid[g] && q.size() != 0) begin
               chk($sformatf("out_tdata[%0d]", g), 32'(o_data[g]), 32'(q[0].data));
               chk($sformatf("out_tlast[%0d]", g), 32'(o_last[g]), 32'(q[0].last));
            end
            prev_stall = o_valid[g] && !out_tready;
            prev_data  = o_data[g];
            prev_last  = o_last[g];
            if (o_valid[g] && out_tready) begin
               if (q.size() != 0) void'(q.pop_front());
               out_cnt++;
               last_data = o_data[g];
               last_cyc  = cyc + 1;
            end
            null_exp = in_tvalid && i_ready[g] && in_tlast && (in_tkeep == 4'b0000);
            if (in_tvalid && i_ready[g]) begin
               total  = $countones(in_tkeep);
               pushed = 0;
               for (int j = 0; j < 4; j++) begin
                  k = (g == 0) ? 3 - j : j;
                  if (in_tkeep[k]) begin
                     e.data = in_tdata[k*8 +: 8];
                     e.last = in_tlast && (pushed == total - 1);
                     q.push_back(e);
                     pushed++;
                  end
               end
            end
         end
      end
   end

   task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l,
                       output int waits);
      logic hs;
      in_tdata  = d;
      in_tkeep  = k;
      in_tlast  = l;
      in_tvalid = 1'b1;
      waits     = 0;
      forever begin
         @(negedge aclk);
         hs = i_ready[0];
         @(posedge aclk);
         #1;
         if (hs) break;
         waits++;
         if (waits > 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=no_handshake required=handshake");
            break;
         end
      end
      in_tvalid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      forever begin
         @(negedge aclk);
         if (!o_valid[0] && !o_valid[1]) break;
         n++;
         if (n > 60) begin
            checks++;
            errors++;
            $display("FAIL %s_drain_timeout actual=busy required=idle", name);
            break;
         end
      end
      @(posedge aclk);
      #1;
   endtask

   vec_t       tbl [6];
   logic [7:0] exp_seq [4];
   logic [3:0] pat;
   int         w, w2, c0, c1, s;

   initial begin
      tbl[0] = '{32'h44332211, 4'b1111, 1'b1, 4, 8'h11, 8'h44};
      tbl[1] = '{32'hDDCCBBAA, 4'b0101, 1'b1, 2, 8'hAA, 8'hCC};
      tbl[2] = '{32'h12345678, 4'b1000, 1'b1, 1, 8'h12, 8'h12};
      tbl[3] = '{32'hCAFEBABE, 4'b0110, 1'b0, 2, 8'hBA, 8'hFE};
      tbl[4] = '{32'h0F0E0D0C, 4'b0001, 1'b0, 1, 8'h0C, 8'h0C};
      tbl[5] = '{32'hA1B2C3D4, 4'b1011, 1'b1, 3, 8'hD4, 8'hA1};
      exp_seq = '{8'h44, 8'h33, 8'h22, 8'h11};
      pat = 4'b1001;

      // Reset state
      repeat (3) @(negedge aclk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_valid", 32'(o_valid[d]), 32'd0);
         chk("rst_last", 32'(o_last[d]), 32'd0);
         chk("rst_data", 32'(o_data[d]), 32'd0);
         chk("rst_null", 32'(n_last[d]), 32'd0);
      end
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      repeat (2) @(posedge aclk);
      #1;

      // MSB-first full beat, cycle by cycle
      send(32'h44332211, 4'b1111, 1'b1, w);
      for (int j = 0; j < 4; j++) begin
         @(negedge aclk);
         chk($sformatf("seq_data%0d", j), 32'(o_data[0]), 32'(exp_seq[j]));
         chk($sformatf("seq_last%0d", j), 32'(o_last[0]), 32'(j == 3));
         chk($sformatf("seq_ready%0d", j), 32'(i_ready[0]), 32'(j == 3));
      end
      @(posedge aclk);
      #1;
      drain("seq");

      // Table of single beats
      for (int i = 0; i < 6; i++) begin
         c0 = g_mon[0].out_cnt;
         c1 = g_mon[1].out_cnt;
         send(tbl[i].data, tbl[i].keep, tbl[i].last, w);
         drain($sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d_cnt_msb", i), 32'(g_mon[0].out_cnt - c0), 32'(tbl[i].n_out));
         chk($sformatf("tbl%0d_cnt_lsb", i), 32'(g_mon[1].out_cnt - c1), 32'(tbl[i].n_out));
         chk($sformatf("tbl%0d_end_msb", i), 32'(g_mon[0].last_data), 32'(tbl[i].last_m));
         chk($sformatf("tbl%0d_end_lsb", i), 32'(g_mon[1].last_data), 32'(tbl[i].last_l));
      end

      // Back-to-back beats: eight outputs with no bubble
      c1 = g_mon[1].out_cnt;
      send(32'h44332211, 4'b1111, 1'b1, w);
      s = cyc;
      send(32'h88776655, 4'b1111, 1'b1, w2);
      drain("b2b");
      chk("b2b_cnt", 32'(g_mon[1].out_cnt - c1), 32'd8);
      chk("b2b_span", 32'(g_mon[1].last_cyc - s), 32'd8);
      chk("b2b_end", 32'(g_mon[1].last_data), 32'h88);

      // Backpressure pattern 1,0,0,1 on a full beat
      c0 = g_mon[0].out_cnt;
      send(32'hF4F3F2F1, 4'b1111, 1'b1, w);
      for (int i = 0; i < 40; i++) begin
         out_tready = pat[i % 4];
         @(negedge aclk);
         if (!o_valid[0] && !o_valid[1]) break;
         @(posedge aclk);
         #1;
      end
      out_tready = 1'b1;
      @(posedge aclk);
      #1;
      chk("bp_cnt", 32'(g_mon[0].out_cnt - c0), 32'd4);
      chk("bp_end", 32'(g_mon[0].last_data), 32'hF1);

      // Null beat followed immediately by a real beat
      c0 = g_mon[0].out_cnt;
      send(32'h99999999, 4'b0000, 1'b1, w);
      chk("null_pulse", 32'(n_last[0]), 32'd1);
      send(32'h44332211, 4'b1111, 1'b1, w2);
      chk("null_next_wait", 32'(w2), 32'd0);
      chk("null_pulse_end", 32'(n_last[0]), 32'd0);
      drain("null");
      chk("null_cnt", 32'(g_mon[0].out_cnt - c0), 32'd4);

      // Async reset after the second sub-word
      send(32'h44332211, 4'b1111, 1'b1, w);
      repeat (2) @(posedge aclk);
      #2;
      aresetn = 1'b0;
      #1;
      chk("arst_valid_msb", 32'(o_valid[0]), 32'd0);
      chk("arst_valid_lsb", 32'(o_valid[1]), 32'd0);
      chk("arst_last", 32'(o_last[0]), 32'd0);
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      c0 = g_mon[0].out_cnt;
      repeat (5) @(posedge aclk);
      #1;
      chk("arst_idle_cnt", 32'(g_mon[0].out_cnt - c0), 32'd0);
      send(32'hDDCCBBAA, 4'b1111, 1'b1, w);
      drain("arst");
      chk("arst_new_cnt", 32'(g_mon[0].out_cnt - c0), 32'd4);

      repeat (2) @(posedge aclk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axis_downsizer_n.md
Name: axis_downsizer_n

Overview:
- AXI4-Stream width down-converter. Splits each W*RATIO-bit input beat into up to RATIO W-bit output beats.
- Per-sub-word keep: sub-words whose keep bit is 0 are skipped. Packet boundaries are carried on tlast.
- Sits between wide datapath producers and narrow consumers in the stream fabric.
- Generalised next generation of the fixed 2:1 downsizer: arbitrary ratio, selectable sub-word order, full-throughput back-to-back operation.

Parameters:
- W, 32, output data width in bits (>=1).
- RATIO, 4, input/output width ratio (>=2); input width is W*RATIO.
- MSB_FIRST, 1, 1: most-significant sub-word is emitted first (2:1 legacy order); 0: least-significant first.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- in_tdata  in  W*RATIO  input beat; sub-word k = bits [k*W +: W].
- in_tkeep  in  RATIO  one bit per sub-word; 1 = sub-word is emitted.
- in_tlast  in  1  input beat ends a packet.
- in_tvalid  in  1  input valid.
- in_tready  out  1  input ready.
- out_tdata  out  W  output sub-word.
- out_tlast  out  1  last sub-word of packet.
- out_tvalid  out  1  output valid.
- out_tready  in  1  output ready.
- null_last  out  1  one-cycle pulse: an input beat with in_tlast=1 and in_tkeep=0 was dropped.

Behaviour:
- Reset: out_tvalid=0, out_tlast=0, out_tdata=0, null_last=0, holding register empty (pending mask=0). Reset mid-packet discards the held beat and any remaining sub-words; nothing is emitted after release until a new input is accepted.
- Storage: one holding register (data, last) plus a RATIO-bit pending mask. The mask is loaded from in_tkeep on accept; out_tvalid = |pending.
- Selection: current index = first set bit of pending, scanning from RATIO-1 down (MSB_FIRST=1) or from 0 up (MSB_FIRST=0).
  - out_tdata = selected sub-word.
  - out_tlast = held last AND selected bit is the only set bit of pending.
  - All outputs are driven from registers/mux of registers; no combinational in_* -> out_* path.
- On out_tvalid & out_tready: clear the selected pending bit.
- in_tready = (pending==0) | (out_tready & pending has exactly one bit set).
  - Combinational from out_tready only.
  - Gives full throughput: the last sub-word of beat n and acceptance of beat n+1 occur in the same cycle.
- On in_tvalid & in_tready: load data/last and pending=in_tkeep. This has priority over the clear in the same cycle.
- Latency: accepted beat presents its first sub-word on out_tvalid the next cycle.
- in_tkeep=0 beat: accepted, produces no output, pending stays 0.
  - If in_tlast=1 it also pulses null_last the next cycle, and no out_tlast is generated for that packet.
- Stall: while out_tvalid=1 & out_tready=0, out_tdata, out_tlast and pending are held stable (AXI rule).
- Single-set keep with tlast: exactly one output beat, with out_tlast=1.
- in_tvalid is not required to stay high. in_tdata is sampled only on handshake.

Decomposition:
- Package axis_dnsz_pkg:
  - index width constant function (clog2 of RATIO).
  - onehot-count helper "is_single_bit".
  - typedef for sub-word index.
- Sub-module dnsz_first_set: parametrised priority encoder (WIDTH, DIR) returning index and valid. Used for sub-word selection.
- Top holds the registers, the ready logic and the output mux.

Test Plan:
- W=8, RATIO=4, MSB_FIRST=1, out_tready=1: in_tdata=0x44332211, tkeep=4'b1111, tlast=1 -> out 0x44,0x33,0x22,0x11 on 4 consecutive cycles, out_tlast only on 0x11; in_tready high in the 4th cycle.
- Same setup, MSB_FIRST=0, two back-to-back beats 0x44332211 then 0x88776655, both keep=1111 -> 8 output beats with no bubble: 11,22,33,44,55,66,77,88.
- Sparse keep: tkeep=4'b0101, tlast=1, data 0xDDCCBBAA, MSB_FIRST=1 -> out 0xCC then 0xAA (tlast=1); exactly 2 beats.
- Backpressure: out_tready toggles 1,0,0,1,... on a full beat -> out_tdata/out_tlast stable while stalled; in_tready=0 until the final sub-word handshakes; no loss or duplication.
- Null beat: tkeep=0, tlast=1 -> no out_tvalid, null_last=1 for exactly one cycle; next beat is accepted the following cycle.
- Async reset asserted after the 2nd sub-word of a full beat -> out_tvalid=0 immediately; after release, out_tvalid stays 0 until a new input is accepted.
